// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
// Shared definitions for the serial pattern matcher: FSM state encoding,
// detection-mode encoding and the legal-range check for the window width.
// -----------------------------------------------------------------------------
package spm_pkg;

  localparam logic ST_FILL     = 1'b0;
  localparam logic ST_ARMED    = 1'b1;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  typedef enum logic {
    S_FILL  = ST_FILL,
    S_ARMED = ST_ARMED
  } spm_state_e;

  // Window width must be at least 2 (the shift needs a [W-2:0] slice) and at
  // most 32 bits.
  function automatic bit spm_pat_w_legal(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

endpackage

// File: rtl/serial_pattern_matcher_if.sv
// -----------------------------------------------------------------------------
// spm_if
// Bundles the serial-bit input, configuration, counter-clear and result
// signals of serial_pattern_matcher.
//   master : bench / upstream side, drives bit_valid, bit_in, cfg_*, cnt_clr
//   slave  : the matcher, drives match_pulse, match_count, window, armed
// -----------------------------------------------------------------------------
interface spm_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);

  logic             bit_valid;
  logic             bit_in;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic [PAT_W-1:0] window;
  logic             armed;

  modport master (
    output bit_valid, bit_in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    input  match_pulse, match_count, window, armed
  );

  modport slave (
    input  bit_valid, bit_in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    output match_pulse, match_count, window, armed
  );

endinterface

// File: rtl/serial_window_reg.sv
// -----------------------------------------------------------------------------
// serial_window_reg
// Serial-in / parallel-out shift window. Newest bit enters at the LSB.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   i_clear       : synchronous clear of the window (config reload)
//   i_shift_en    : accept i_bit_in on this edge
//   i_bit_in      : serial data bit
//   o_window      : registered window contents
//   o_next_window : window value as it will be once i_bit_in is accepted
// -----------------------------------------------------------------------------
module serial_window_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_shift_en,
  input  logic         i_bit_in,
  output logic [W-1:0] o_window,
  output logic [W-1:0] o_next_window
);

  logic [W-1:0] r_window;

  assign o_next_window = {r_window[W-2:0], i_bit_in};
  assign o_window      = r_window;

  // Window register: reset and clear both discard any partial contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window <= {W{1'b0}};
    end else if (i_clear) begin
      r_window <= {W{1'b0}};
    end else if (i_shift_en) begin
      r_window <= o_next_window;
    end else begin
      r_window <= r_window;
    end
  end

endmodule

// File: rtl/serial_pattern_matcher.sv
// -----------------------------------------------------------------------------
// serial_pattern_matcher
// Shifts qualified serial bits into a PAT_W-bit window and compares the window
// against a runtime-loaded pattern/mask. Produces a registered one-cycle pulse
// per hit and a saturating hit counter; overlapping or non-overlapping mode.
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset
//   bus : spm_if slave modport (bit stream, config, cnt_clr in;
//         match_pulse, match_count, window, armed out)
// -----------------------------------------------------------------------------
module serial_pattern_matcher
  import spm_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input logic  clk,
  input logic  rst,
  spm_if.slave bus
);

  if (!spm_pat_w_legal(PAT_W)) begin : g_bad_pat_w
    $error("serial_pattern_matcher: PAT_W must be in 2..32");
  end

  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  spm_state_e        r_state;
  spm_state_e        w_state_nxt;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_mask;
  logic              r_ovl;
  logic              r_pulse;
  logic [CNT_W-1:0]  r_count;

  logic [PAT_W-1:0]  w_window;
  logic [PAT_W-1:0]  w_next_window;
  logic              w_accept;
  logic              w_last_fill;
  logic              w_cmp_en;
  logic              w_hit;
  logic              w_drop_arm;

  // A config load takes priority over a coincident bit, which is dropped.
  assign w_accept    = bus.bit_valid & ~bus.cfg_load;
  assign w_last_fill = (r_fill == LAST_FILL);
  // Compare once armed, or on the bit that completes the fill.
  assign w_cmp_en    = w_accept & ((r_state == S_ARMED) | w_last_fill);
  assign w_hit       = w_cmp_en & (((w_next_window ^ r_pat) & r_mask) == {PAT_W{1'b0}});
  assign w_drop_arm  = w_hit & (r_ovl == MODE_NONOVL);

  serial_window_reg #(
    .W (PAT_W)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (bus.cfg_load),
    .i_shift_en    (w_accept),
    .i_bit_in      (bus.bit_in),
    .o_window      (w_window),
    .o_next_window (w_next_window)
  );

  // Next-state and fill-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    if (bus.cfg_load) begin
      w_state_nxt = S_FILL;
      w_fill_nxt  = {FILL_W{1'b0}};
    end else if (w_accept) begin
      case (r_state)
        S_FILL: begin
          if (w_last_fill) begin
            // A non-overlap hit on the completing bit re-arms from scratch.
            w_state_nxt = w_drop_arm ? S_FILL : S_ARMED;
            w_fill_nxt  = {FILL_W{1'b0}};
          end else begin
            w_fill_nxt  = r_fill + FILL_W'(1);
          end
        end
        S_ARMED: begin
          if (w_drop_arm) begin
            // Window contents are kept; only the arming is reset.
            w_state_nxt = S_FILL;
            w_fill_nxt  = {FILL_W{1'b0}};
          end else begin
            w_state_nxt = S_ARMED;
          end
        end
        default: begin
          w_state_nxt = S_FILL;
          w_fill_nxt  = {FILL_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and fill counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_fill  <= {FILL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Configuration registers, captured only on cfg_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= {PAT_W{1'b0}};
      r_mask <= {PAT_W{1'b1}};
      r_ovl  <= MODE_OVL;
    end else if (bus.cfg_load) begin
      r_pat  <= bus.cfg_pattern;
      r_mask <= bus.cfg_mask;
      r_ovl  <= bus.cfg_overlap;
    end else begin
      r_pat  <= r_pat;
      r_mask <= r_mask;
      r_ovl  <= r_ovl;
    end
  end

  // Match pulse: registered on the accepting edge, one cycle per hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_hit;
    end
  end

  // Saturating hit counter; a clear wins over a coincident hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_hit && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign bus.match_pulse = r_pulse;
  assign bus.match_count = r_count;
  assign bus.window      = w_window;
  assign bus.armed       = (r_state == S_ARMED);

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_matcher
// Three matcher instances: A (PAT_W=4, CNT_W=16) driven from a vector table,
// B (PAT_W=8) for masked compares, C (PAT_W=4, CNT_W=2) for saturation.
// -----------------------------------------------------------------------------
module tb_serial_pattern_matcher;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  spm_if #(.PAT_W(4), .CNT_W(16)) ifa ();
  spm_if #(.PAT_W(8), .CNT_W(16)) ifb ();
  spm_if #(.PAT_W(4), .CNT_W(2))  ifc ();

  serial_pattern_matcher #(.PAT_W(4), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  serial_pattern_matcher #(.PAT_W(8), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  serial_pattern_matcher #(.PAT_W(4), .CNT_W(2))  u_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        load;
    logic [3:0]  pat;
    logic [3:0]  mask;
    logic        ovl;
    logic        clr;
    logic        bv;
    logic        bi;
    logic        exp_pulse;
    logic        exp_armed;
    logic [3:0]  exp_window;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int r, input int l, input int pat, input int mask, input int o,
                     input int clr, input int bv, input int bi,
                     input int p, input int a, input int w, input int c);
    vec_t v;
    v.rst = 1'(r);  v.load = 1'(l);  v.pat = 4'(pat);  v.mask = 4'(mask);
    v.ovl = 1'(o);  v.clr = 1'(clr); v.bv = 1'(bv);    v.bi = 1'(bi);
    v.exp_pulse = 1'(p); v.exp_armed = 1'(a); v.exp_window = 4'(w); v.exp_count = 16'(c);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic b_cycle(input logic load, input logic [7:0] pat, input logic [7:0] mask,
                         input logic ovl, input logic clr, input logic bv, input logic bi);
    @(negedge clk);
    ifb.cfg_load = load; ifb.cfg_pattern = pat; ifb.cfg_mask = mask; ifb.cfg_overlap = ovl;
    ifb.cnt_clr = clr;   ifb.bit_valid = bv;    ifb.bit_in = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic c_cycle(input logic load, input logic [3:0] pat, input logic [3:0] mask,
                         input logic ovl, input logic clr, input logic bv, input logic bi);
    @(negedge clk);
    ifc.cfg_load = load; ifc.cfg_pattern = pat; ifc.cfg_mask = mask; ifc.cfg_overlap = ovl;
    ifc.cnt_clr = clr;   ifc.bit_valid = bv;    ifc.bit_in = bi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ifa.bit_valid = 1'b0; ifa.bit_in = 1'b0; ifa.cfg_load = 1'b0; ifa.cfg_pattern = 4'h0;
    ifa.cfg_mask = 4'h0;  ifa.cfg_overlap = 1'b0; ifa.cnt_clr = 1'b0;
    ifb.bit_valid = 1'b0; ifb.bit_in = 1'b0; ifb.cfg_load = 1'b0; ifb.cfg_pattern = 8'h00;
    ifb.cfg_mask = 8'h00; ifb.cfg_overlap = 1'b0; ifb.cnt_clr = 1'b0;
    ifc.bit_valid = 1'b0; ifc.bit_in = 1'b0; ifc.cfg_load = 1'b0; ifc.cfg_pattern = 4'h0;
    ifc.cfg_mask = 4'h0;  ifc.cfg_overlap = 1'b0; ifc.cnt_clr = 1'b0;

    //  rst ld pat  mask ovl clr bv bi   pulse armed window count
    add(1, 0, 0,   0,   0,  0,  0, 0,   0, 0, 4'h0, 0);   // reset state
    add(0, 1, 4'hB, 4'hF, 1, 0,  0, 0,   0, 0, 4'h0, 0);   // overlap mode, 1011
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h1, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h2, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h5, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   1, 1, 4'hB, 1);   // 4th bit completes fill: hit
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 1, 4'h6, 1);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 1, 4'hD, 1);
    add(0, 0, 0,   0,   0,  0,  1, 1,   1, 1, 4'hB, 2);   // 7th bit: overlapping hit
    add(0, 0, 0,   0,   0,  0,  0, 0,   0, 1, 4'hB, 2);   // no bit, no pulse
    add(0, 1, 4'hB, 4'hF, 0, 1,  0, 0,   0, 0, 4'h0, 0);   // non-overlap mode
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h1, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h2, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h5, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   1, 0, 4'hB, 1);   // hit disarms
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h6, 1);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'hD, 1);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'hB, 1);   // matches but still filling
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 1, 4'h6, 1);   // 4 fresh bits: armed, no hit
    add(0, 1, 4'hB, 4'hF, 1, 1,  0, 0,   0, 0, 4'h0, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h1, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h2, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h5, 0);
    add(0, 1, 4'hB, 4'hF, 1, 0,  1, 1,   0, 0, 4'h0, 0);   // load with bit: bit dropped
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h1, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h2, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h5, 0);
    add(0, 0, 0,   0,   0,  0,  1, 1,   1, 1, 4'hB, 1);
    add(0, 1, 4'hB, 4'hF, 1, 0,  0, 0,   0, 0, 4'h0, 1);   // load keeps count
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h1, 1);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h3, 1);
    add(1, 0, 0,   0,   0,  0,  1, 1,   0, 0, 4'h0, 0);   // rst mid-fill beats bit
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h0, 0);   // reset config: pattern 0000
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h0, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   0, 0, 4'h0, 0);
    add(0, 0, 0,   0,   0,  0,  1, 0,   1, 1, 4'h0, 1);
    add(0, 0, 0,   0,   0,  0,  1, 0,   1, 1, 4'h0, 2);
    add(0, 0, 0,   0,   0,  0,  1, 1,   0, 1, 4'h1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      ifa.cfg_load = vecs[i].load; ifa.cfg_pattern = vecs[i].pat; ifa.cfg_mask = vecs[i].mask;
      ifa.cfg_overlap = vecs[i].ovl; ifa.cnt_clr = vecs[i].clr;
      ifa.bit_valid = vecs[i].bv; ifa.bit_in = vecs[i].bi;
      @(posedge clk);
      #1;
      chk($sformatf("A[%0d] pulse", i),  32'(ifa.match_pulse), 32'(vecs[i].exp_pulse));
      chk($sformatf("A[%0d] armed", i),  32'(ifa.armed),       32'(vecs[i].exp_armed));
      chk($sformatf("A[%0d] window", i), 32'(ifa.window),      32'(vecs[i].exp_window));
      chk($sformatf("A[%0d] count", i),  32'(ifa.match_count), 32'(vecs[i].exp_count));
    end
    @(negedge clk);
    rst = 1'b0;
    ifa.bit_valid = 1'b0; ifa.cfg_load = 1'b0; ifa.cnt_clr = 1'b0;

    // B: pattern A5, mask F0 -> only the upper nibble A matters.
    b_cycle(1'b1, 8'hA5, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("B load window", 32'(ifb.window), 32'h0);
    s = 8'hA3;
    for (int k = 0; k < 8; k++) begin
      b_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, s[7-k]);
      chk($sformatf("B A3 bit%0d pulse", k), 32'(ifb.match_pulse), (k == 7) ? 32'd1 : 32'd0);
    end
    chk("B A3 window", 32'(ifb.window), 32'hA3);
    chk("B A3 count", 32'(ifb.match_count), 32'd1);
    s = 8'hB5;
    for (int k = 0; k < 8; k++) begin
      b_cycle(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, s[7-k]);
      chk($sformatf("B B5 bit%0d pulse", k), 32'(ifb.match_pulse), 32'd0);
    end
    chk("B B5 window", 32'(ifb.window), 32'hB5);
    chk("B B5 count", 32'(ifb.match_count), 32'd1);
    // Zero mask, non-overlap: hit exactly on the bit completing each fill.
    b_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    s = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      b_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, s[7-k]);
      chk($sformatf("B mask0 bit%0d pulse", k), 32'(ifb.match_pulse), (k == 7) ? 32'd1 : 32'd0);
    end
    chk("B mask0 count", 32'(ifb.match_count), 32'd2);
    chk("B mask0 armed", 32'(ifb.armed), 32'd0);
    b_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("B mask0 refill pulse", 32'(ifb.match_pulse), 32'd0);
    b_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // C: 2-bit saturating counter, pattern 1111 on a constant-ones stream.
    c_cycle(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      c_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("C fill%0d pulse", k), 32'(ifc.match_pulse), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      c_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("C hit%0d pulse", k), 32'(ifc.match_pulse), 32'd1);
      chk($sformatf("C hit%0d count", k), 32'(ifc.match_count), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    c_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("C clr+hit pulse", 32'(ifc.match_pulse), 32'd1);
    chk("C clr+hit count", 32'(ifc.match_count), 32'd0);
    c_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("C after clr count", 32'(ifc.match_count), 32'd1);
    c_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("C idle pulse", 32'(ifc.match_pulse), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
